// File: rtl/usb_report_fifo.sv
// First-word-fall-through report buffer for HID words arriving from the USB CDC.
// Writes are never back-pressured; words arriving while full are dropped and counted.
module usb_report_fifo #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 8,
  parameter int EDGE_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic                       axi_clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       in_valid_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o,
  output logic [CNT_W-1:0]           drop_cnt_o,
  input  logic                       clear_ovf_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic              r_in_valid_q;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;
  logic w_accept;
  logic w_drop;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_wr     = (EDGE_MODE != 0) ? (in_valid_i & ~r_in_valid_q) : in_valid_i;
  assign w_rd     = ~w_empty & out_ready_i;
  // A pop frees the slot in the same cycle, so a full buffer can still take a write.
  assign w_accept = w_wr & (~w_full | w_rd);
  assign w_drop   = w_wr & w_full & ~w_rd;

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_in_valid_q <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_in_valid_q <= in_valid_i;
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd)     r_rd_ptr <= r_rd_ptr + PW'(1);
      // Clear has priority over a drop landing in the same cycle.
      if (clear_ovf_i) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != {CNT_W{1'b1}}) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge axi_clk) begin
    if (!rst && w_accept) r_mem[r_wr_ptr[AW-1:0]] <= in_data_i;
  end

  assign out_data_o  = r_mem[r_rd_ptr[AW-1:0]];
  assign out_valid_o = ~w_empty;
  assign count_o     = r_wr_ptr - r_rd_ptr;
  assign full_o      = w_full;
  assign empty_o     = w_empty;
  assign overflow_o  = r_overflow;
  assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_usb_report_fifo.sv
// Directed bench for usb_report_fifo: default build, edge-mode build, and a
// small saturating-counter build, all on one clock.
module tb_usb_report_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: defaults (64-bit, DEPTH 8, level mode, 16-bit counter)
  logic        a_rst, a_valid, a_ready, a_clr;
  logic [63:0] a_din, a_dout;
  logic        a_ovalid, a_full, a_empty, a_ovf;
  logic [3:0]  a_count;
  logic [15:0] a_drop;

  usb_report_fifo u_a (
    .axi_clk(clk), .rst(a_rst), .in_data_i(a_din), .in_valid_i(a_valid),
    .out_data_o(a_dout), .out_valid_o(a_ovalid), .out_ready_i(a_ready),
    .count_o(a_count), .full_o(a_full), .empty_o(a_empty),
    .overflow_o(a_ovf), .drop_cnt_o(a_drop), .clear_ovf_i(a_clr)
  );

  // Instance B: edge mode
  logic        b_rst, b_valid, b_ready, b_clr;
  logic [15:0] b_din, b_dout;
  logic        b_ovalid, b_full, b_empty, b_ovf;
  logic [3:0]  b_count;
  logic [15:0] b_drop;

  usb_report_fifo #(.DATA_W(16), .DEPTH(8), .EDGE_MODE(1), .CNT_W(16)) u_b (
    .axi_clk(clk), .rst(b_rst), .in_data_i(b_din), .in_valid_i(b_valid),
    .out_data_o(b_dout), .out_valid_o(b_ovalid), .out_ready_i(b_ready),
    .count_o(b_count), .full_o(b_full), .empty_o(b_empty),
    .overflow_o(b_ovf), .drop_cnt_o(b_drop), .clear_ovf_i(b_clr)
  );

  // Instance C: DEPTH 4, 2-bit drop counter
  logic        c_rst, c_valid, c_ready, c_clr;
  logic [15:0] c_din, c_dout;
  logic        c_ovalid, c_full, c_empty, c_ovf;
  logic [2:0]  c_count;
  logic [1:0]  c_drop;

  usb_report_fifo #(.DATA_W(16), .DEPTH(4), .EDGE_MODE(0), .CNT_W(2)) u_c (
    .axi_clk(clk), .rst(c_rst), .in_data_i(c_din), .in_valid_i(c_valid),
    .out_data_o(c_dout), .out_valid_o(c_ovalid), .out_ready_i(c_ready),
    .count_o(c_count), .full_o(c_full), .empty_o(c_empty),
    .overflow_o(c_ovf), .drop_cnt_o(c_drop), .clear_ovf_i(c_clr)
  );

  // Inputs change 1 ns after a rising edge; outputs are read at that same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_valid = 1'b0; a_ready = 1'b0; a_clr = 1'b0; a_din = '0;
    b_valid = 1'b0; b_ready = 1'b0; b_clr = 1'b0; b_din = '0;
    c_valid = 1'b0; c_ready = 1'b0; c_clr = 1'b0; c_din = '0;
    tick(); tick();
    n_checks++;
    if (a_ovalid !== 1'b0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_flags: valid=%b empty=%b full=%b count=%0d, want 0 1 0 0",
               a_ovalid, a_empty, a_full, a_count);
    end
    n_checks++;
    if (a_ovf !== 1'b0 || a_drop !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_ovf: ovf=%b drop=%0d, want 0 0", a_ovf, a_drop);
    end
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
  endtask

  task automatic test_basic();
    a_valid = 1'b1; a_din = 64'h1111_1111_1111_1111;
    tick();
    n_checks++;
    if (a_ovalid !== 1'b1 || a_count !== 4'd1) begin
      n_fail++;
      $display("FAIL latency: valid=%b count=%0d, want 1 1", a_ovalid, a_count);
    end
    a_din = 64'h2222_2222_2222_2222; tick();
    a_din = 64'h3333_3333_3333_3333; tick();
    a_valid = 1'b0;
    n_checks++;
    if (a_count !== 4'd3 || a_dout !== 64'h1111_1111_1111_1111) begin
      n_fail++;
      $display("FAIL basic_fill: count=%0d data=%h, want 3 1111111111111111", a_count, a_dout);
    end
    tick();
    n_checks++;
    if (a_dout !== 64'h1111_1111_1111_1111 || a_count !== 4'd3) begin
      n_fail++;
      $display("FAIL basic_hold: data=%h count=%0d, want 1111111111111111 3", a_dout, a_count);
    end
    a_ready = 1'b1;
    tick();
    n_checks++;
    if (a_dout !== 64'h2222_2222_2222_2222 || a_count !== 4'd2) begin
      n_fail++;
      $display("FAIL basic_pop1: data=%h count=%0d, want 2222222222222222 2", a_dout, a_count);
    end
    tick();
    n_checks++;
    if (a_dout !== 64'h3333_3333_3333_3333 || a_count !== 4'd1) begin
      n_fail++;
      $display("FAIL basic_pop2: data=%h count=%0d, want 3333333333333333 1", a_dout, a_count);
    end
    tick();
    n_checks++;
    if (a_empty !== 1'b1 || a_ovalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_empty: empty=%b valid=%b, want 1 0", a_empty, a_ovalid);
    end
    a_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [63:0] exp;
    for (int i = 0; i < 10; i++) begin
      a_valid = 1'b1; a_din = 64'h00A0 + 64'(i);
      tick();
      if (i == 7) begin
        n_checks++;
        if (a_full !== 1'b1 || a_count !== 4'd8 || a_drop !== 16'd0) begin
          n_fail++;
          $display("FAIL ovf_full8: full=%b count=%0d drop=%0d, want 1 8 0", a_full, a_count, a_drop);
        end
      end
    end
    a_valid = 1'b0;
    n_checks++;
    if (a_drop !== 16'd2 || a_ovf !== 1'b1 || a_count !== 4'd8) begin
      n_fail++;
      $display("FAIL ovf_drop: drop=%0d ovf=%b count=%0d, want 2 1 8", a_drop, a_ovf, a_count);
    end
    // Write and pop together on a full buffer: the write must land.
    a_valid = 1'b1; a_din = 64'h00BB; a_ready = 1'b1;
    tick();
    a_valid = 1'b0;
    n_checks++;
    if (a_count !== 4'd8 || a_drop !== 16'd2 || a_dout !== 64'h00A1) begin
      n_fail++;
      $display("FAIL full_wr_rd: count=%0d drop=%0d data=%h, want 8 2 a1", a_count, a_drop, a_dout);
    end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? (64'h00A1 + 64'(i)) : 64'h00BB;
      n_checks++;
      if (a_ovalid !== 1'b1 || a_dout !== exp) begin
        n_fail++;
        $display("FAIL ovf_read%0d: valid=%b data=%h, want 1 %h", i, a_ovalid, a_dout, exp);
      end
      tick();
    end
    a_ready = 1'b0;
    n_checks++;
    if (a_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drained: empty=%b, want 1", a_empty);
    end
    a_clr = 1'b1; tick(); a_clr = 1'b0;
    n_checks++;
    if (a_ovf !== 1'b0 || a_drop !== 16'd0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b drop=%0d, want 0 0", a_ovf, a_drop);
    end
  endtask

  task automatic test_back_to_back();
    int exp_v = 0;
    for (int i = 0; i < 24; i++) begin
      a_valid = 1'b1; a_ready = 1'b1; a_din = 64'(i);
      if (a_ovalid === 1'b1) begin
        n_checks++;
        if (a_dout !== 64'(exp_v)) begin
          n_fail++;
          $display("FAIL b2b_data: got %h, want %h", a_dout, 64'(exp_v));
        end
        exp_v++;
      end
      tick();
      if (i > 0) begin
        n_checks++;
        if (a_count !== 4'd1) begin
          n_fail++;
          $display("FAIL b2b_count%0d: count=%0d, want 1", i, a_count);
        end
      end
    end
    a_valid = 1'b0;
    for (int k = 0; k < 10 && a_empty !== 1'b1; k++) begin
      if (a_ovalid === 1'b1) begin
        n_checks++;
        if (a_dout !== 64'(exp_v)) begin
          n_fail++;
          $display("FAIL b2b_drain: got %h, want %h", a_dout, 64'(exp_v));
        end
        exp_v++;
      end
      tick();
    end
    a_ready = 1'b0;
    n_checks++;
    if (exp_v != 24 || a_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_total: words=%0d empty=%b, want 24 1", exp_v, a_empty);
    end
  endtask

  task automatic test_edge_mode();
    for (int i = 0; i < 5; i++) begin
      b_valid = 1'b1; b_din = 16'h0100 + 16'(i); tick();
    end
    b_valid = 1'b0; tick();
    for (int i = 0; i < 2; i++) begin
      b_valid = 1'b1; b_din = 16'h0200 + 16'(i); tick();
    end
    b_valid = 1'b0; tick();
    n_checks++;
    if (b_count !== 4'd2 || b_dout !== 16'h0100) begin
      n_fail++;
      $display("FAIL edge_count: count=%0d data=%h, want 2 0100", b_count, b_dout);
    end
    b_ready = 1'b1; tick();
    n_checks++;
    if (b_dout !== 16'h0200 || b_count !== 4'd1) begin
      n_fail++;
      $display("FAIL edge_second: data=%h count=%0d, want 0200 1", b_dout, b_count);
    end
    tick(); b_ready = 1'b0;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 9; i++) begin
      c_valid = 1'b1; c_din = 16'h0C00 + 16'(i); tick();
    end
    c_valid = 1'b0;
    n_checks++;
    if (c_drop !== 2'd3 || c_ovf !== 1'b1 || c_count !== 3'd4 || c_full !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_drop: drop=%0d ovf=%b count=%0d full=%b, want 3 1 4 1",
               c_drop, c_ovf, c_count, c_full);
    end
    c_clr = 1'b1; c_valid = 1'b1; c_din = 16'hDEAD; tick();
    c_clr = 1'b0; c_valid = 1'b0;
    n_checks++;
    if (c_drop !== 2'd0 || c_ovf !== 1'b0 || c_count !== 3'd4 || c_dout !== 16'h0C00) begin
      n_fail++;
      $display("FAIL sat_clear_wins: drop=%0d ovf=%b count=%0d data=%h, want 0 0 4 0c00",
               c_drop, c_ovf, c_count, c_dout);
    end
    // Reset with a full buffer and a competing write in the same cycle.
    c_rst = 1'b1; c_valid = 1'b1; c_ready = 1'b1; tick();
    c_rst = 1'b0; c_valid = 1'b0; c_ready = 1'b0;
    n_checks++;
    if (c_empty !== 1'b1 || c_ovalid !== 1'b0 || c_count !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset: empty=%b valid=%b count=%0d, want 1 0 0", c_empty, c_ovalid, c_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_edge_mode();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
